seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed hexadecimal 7-segment display driver. It scans DIGITS hex digits across one shared segment bus using a one-hot digit enable. Each digit has its own blanking and decimal point. New values are double-buffered and applied only at a frame boundary, so a frame never shows a mix of old and new data. It sits between datapath/debug registers and the board display pins, and replaces the single-digit combinational decoder in display paths.

---
 rtl/seg7_scan_driver.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed hex 7-segment scan driver with frame-aligned double buffering
// Optional: SEG7_LZS_EN enables leading-zero suppression on the active set.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic [4*DIGITS-1:0]   sh_value_q, sh_value_d, act_value_q, act_value_d;
    logic [DIGITS-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]     sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_out_q, dp_out_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick, wrap;
    logic [DIGITS-1:0]     lz;
    logic [DIGITS-1:0]     blank_sh, dp_sh, lz_sh;
    logic [3:0]            nib;

    // Suppression looks at the active set as it will be after this edge, so
    // a freshly applied frame is suppressed correctly from digit 0 onward.
`ifdef SEG7_LZS_EN
    always_comb begin
        logic allz;
        allz = 1'b1;
        lz   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            allz  = allz & (act_value_d[4*k +: 4] == 4'h0);
            lz[k] = allz & (k != 0);
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        tick = (cnt_q == CNT_LAST);
        wrap = tick && (idx_q == IDX_LAST);

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        sh_value_d = sh_value_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        if (load) begin
            sh_value_d = value;
            sh_dp_d    = dp;
            sh_blank_d = blank;
        end
        busy_d = load | (busy_q & ~wrap);

        // The apply uses the pre-edge shadow, so a load on the wrap edge waits a frame.
        act_value_d = act_value_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        if (wrap && busy_q) begin
            act_value_d = sh_value_q;
            act_dp_d    = sh_dp_q;
            act_blank_d = sh_blank_q;
        end

        blank_sh = act_blank_d >> idx_d;
        dp_sh    = act_dp_d >> idx_d;
        lz_sh    = lz >> idx_d;
        nib      = 4'(act_value_d >> {idx_d, 2'b00});

        an_d     = an_q;
        seg_d    = seg_q;
        dp_out_d = dp_out_q;
        if (tick) begin
            an_d     = DIGITS'(1) << idx_d;
            seg_d    = (blank_sh[0] | lz_sh[0]) ? 7'b0 : decode(nib);
            dp_out_d = dp_sh[0] & ~blank_sh[0];
        end
        frame_done_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            sh_value_q   <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '1;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            seg_q        <= '0;
            dp_out_q     <= 1'b0;
            an_q         <= DIGITS'(1);
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            sh_value_q   <= sh_value_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = busy_q;
    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - table-driven bench for seg7_scan_driver (4x4 and 1x1 instances)
module tb_seg7_scan_driver;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp, blank;
    logic        busy, dp_out, frame_done;
    logic [6:0]  seg;
    logic [3:0]  an;

    logic        load1;
    logic [3:0]  value1;
    logic        dp1, blank1;
    logic        busy1, dp_out1, frame_done1;
    logic [6:0]  seg1;
    logic        an1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(RD)) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp), .blank(blank),
        .busy(busy), .seg(seg), .dp_out(dp_out), .an(an), .frame_done(frame_done)
    );

    seg7_scan_driver #(.DIGITS(1), .REFRESH_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load(load1), .value(value1), .dp(dp1), .blank(blank1),
        .busy(busy1), .seg(seg1), .dp_out(dp_out1), .an(an1), .frame_done(frame_done1)
    );

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [27:0] seg;
        logic [3:0]  dpo;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_fd();
        int k = 0;
        while (frame_done !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk("frame_done_wait", {31'b0, frame_done}, 32'd1);
    endtask

    // Called at a frame_done sample point; walks the four digit slots and
    // returns at the next frame_done sample point.
    task automatic check_frame(input string name, input logic [27:0] es, input logic [3:0] ed);
        for (int d = 0; d < 4; d++) begin
            chk({name, "_an"}, {28'b0, an}, 32'(4'b0001 << d));
            chk({name, "_seg"}, {25'b0, seg}, {25'b0, es[7*d +: 7]});
            chk({name, "_dp"}, {31'b0, dp_out}, {31'b0, ed[d]});
            chk({name, "_fd"}, {31'b0, frame_done}, (d == 0) ? 32'd1 : 32'd0);
            repeat (RD) @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        load  = 1'b1;
        value = v;
        dp    = d;
        blank = b;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000};
        vecs[1] = '{16'h8888, 4'b0101, 4'b0100, {7'h7F, 7'h00, 7'h7F, 7'h7F}, 4'b0001};
`ifdef SEG7_LZS_EN
        vecs[2] = '{16'h0050, 4'b0000, 4'b0000, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000};
        vecs[3] = '{16'h0000, 4'b0000, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
        vecs[5] = '{16'h0E07, 4'b0010, 4'b0001, {7'h00, 7'h79, 7'h3F, 7'h00}, 4'b0010};
`else
        vecs[2] = '{16'h0050, 4'b0000, 4'b0000, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b0000};
        vecs[3] = '{16'h0000, 4'b0000, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000};
        vecs[5] = '{16'h0E07, 4'b0010, 4'b0001, {7'h3F, 7'h79, 7'h3F, 7'h00}, 4'b0010};
`endif
        vecs[4] = '{16'hD4B6, 4'b1000, 4'b0000, {7'h5E, 7'h66, 7'h7C, 7'h7D}, 4'b1000};

        rst_n = 1'b0; load = 1'b0; value = '0; dp = '0; blank = '0;
        load1 = 1'b0; value1 = '0; dp1 = 1'b0; blank1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", {28'b0, an}, 32'h1);
        chk("rst_seg", {25'b0, seg}, 32'h0);
        chk("rst_dp", {31'b0, dp_out}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_fd", {31'b0, frame_done}, 32'h0);
        chk("rst_an1", {31'b0, an1}, 32'h1);
        chk("rst_fd1", {31'b0, frame_done1}, 32'h0);
        rst_n = 1'b1;

        // single-digit, divide-by-one instance: every edge is a wrap edge
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("d1_an", {31'b0, an1}, 32'h1);
            chk("d1_fd", {31'b0, frame_done1}, 32'h1);
            chk("d1_seg_dark", {25'b0, seg1}, 32'h0);
        end
        load1 = 1'b1; value1 = 4'h5; dp1 = 1'b1; blank1 = 1'b0;
        @(negedge clk);
        load1 = 1'b0;
        chk("d1_busy_set", {31'b0, busy1}, 32'h1);
        chk("d1_seg_old", {25'b0, seg1}, 32'h0);
        @(negedge clk);
        chk("d1_busy_clr", {31'b0, busy1}, 32'h0);
        chk("d1_seg_new", {25'b0, seg1}, 32'h6D);
        chk("d1_dp_new", {31'b0, dp_out1}, 32'h1);
        chk("d1_fd_new", {31'b0, frame_done1}, 32'h1);

        wait_fd();
        check_frame("dark", 28'h0, 4'b0000);

        for (int v = 0; v < 6; v++) begin
            do_load(vecs[v].value, vecs[v].dp, vecs[v].blank);
            chk("vec_busy_set", {31'b0, busy}, 32'h1);
            wait_fd();
            chk("vec_busy_clr", {31'b0, busy}, 32'h0);
            check_frame($sformatf("vec%0d", v), vecs[v].seg, vecs[v].dpo);
        end

        // pending 2222, then 3333 loaded exactly on the next wrap edge
        do_load(16'h2222, 4'b0000, 4'b0000);
        repeat (14) @(negedge clk);
        chk("wrapload_pre_fd", {31'b0, frame_done}, 32'h0);
        chk("wrapload_pre_an", {28'b0, an}, 32'h8);
        do_load(16'h3333, 4'b0000, 4'b0000);
        chk("wrapload_fd1", {31'b0, frame_done}, 32'h1);
        chk("wrapload_busy1", {31'b0, busy}, 32'h1);
        chk("wrapload_seg2", {25'b0, seg}, 32'h5B);
        repeat (15) @(negedge clk);
        chk("wrapload_busy_hold", {31'b0, busy}, 32'h1);
        chk("wrapload_fd_mid", {31'b0, frame_done}, 32'h0);
        @(negedge clk);
        chk("wrapload_fd2", {31'b0, frame_done}, 32'h1);
        chk("wrapload_busy2", {31'b0, busy}, 32'h0);
        check_frame("wrapload_3", {7'h4F, 7'h4F, 7'h4F, 7'h4F}, 4'b0000);

        // two loads in one frame: last one wins
        do_load(16'h1111, 4'b0000, 4'b0000);
        do_load(16'h2222, 4'b0000, 4'b0000);
        chk("twoload_busy", {31'b0, busy}, 32'h1);
        wait_fd();
        check_frame("twoload", {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);

        // reset mid-frame with a load pending
        do_load(16'h4444, 4'b0000, 4'b0000);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_an", {28'b0, an}, 32'h1);
        chk("mrst_seg", {25'b0, seg}, 32'h0);
        chk("mrst_busy", {31'b0, busy}, 32'h0);
        chk("mrst_an1", {31'b0, an1}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_an_hold", {28'b0, an}, 32'h1);
        @(negedge clk);
        chk("mrst_an_next", {28'b0, an}, 32'h2);
        chk("mrst_seg_dark", {25'b0, seg}, 32'h0);
        wait_fd();
        chk("mrst_lost_busy", {31'b0, busy}, 32'h0);
        check_frame("mrst_lost", 28'h0, 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
